// File: rtl/rpsc_ps_interlock.sv
// rpsc_ps_interlock
//   Multi-channel power-supply interlock and sequencer for RPSC cards.
//   NUM_CH supply channels are cascaded: channel k may only switch on once
//   channel k-1 reports ch_ok, which enforces the power-up order (for
//   example G1 before anode). Each channel has its own fault group, its own
//   settle timer (SETTLE_BASE*(k+1) cycles) and a trip-latching state machine.
//
//   Optional build macro RPSC_FAULT_FILTER_EN: when defined, every fault bit
//   passes through a 2-flop synchronizer and a 3-sample debounce before it
//   reaches the channel logic.
//
// Ports
//   clk        in   system clock, all state on the rising edge
//   reset      in   asynchronous, active-high reset
//   fault      in   [NUM_CH*NUM_FAULTS] faults, channel k owns [k*NUM_FAULTS +: NUM_FAULTS]
//   ext_ready  in   [NUM_CH] external readiness per channel
//   ps_act     in   [NUM_CH] supply-active feedback per channel
//   u_low      in   [NUM_CH] output-voltage-low flag per channel
//   clear      in   single-cycle trip acknowledge, all channels
//   on_perm    out  [NUM_CH] switch-on permission (combinational)
//   ch_ok      out  [NUM_CH] channel settled and healthy (registered)
//   alarm      out  [NUM_CH] latched trip (registered)
//   trip_cause out  [2*NUM_CH] per channel 00 none, 01 fault, 10 undervoltage
//   busy       out  [NUM_CH] channel ramping (registered)
module rpsc_ps_interlock #(
    parameter  int NUM_CH      = 2,
    parameter  int NUM_FAULTS  = 7,
    parameter  int SETTLE_BASE = 128,
    localparam int CNT_W       = $clog2(SETTLE_BASE * NUM_CH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CH*NUM_FAULTS-1:0]   fault,
    input  logic [NUM_CH-1:0]              ext_ready,
    input  logic [NUM_CH-1:0]              ps_act,
    input  logic [NUM_CH-1:0]              u_low,
    input  logic                           clear,
    output logic [NUM_CH-1:0]              on_perm,
    output logic [NUM_CH-1:0]              ch_ok,
    output logic [NUM_CH-1:0]              alarm,
    output logic [2*NUM_CH-1:0]            trip_cause,
    output logic [NUM_CH-1:0]              busy
);

    localparam int FW = NUM_CH * NUM_FAULTS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        OK   = 2'd2,
        TRIP = 2'd3
    } state_e;

    logic [FW-1:0] fault_f;

`ifdef RPSC_FAULT_FILTER_EN
    // s1/s2 synchronize; h1/h2 hold the two previous synchronized samples.
    // A bit is asserted only while three consecutive samples are high and
    // drops as soon as the newest synchronized sample is low.
    logic [FW-1:0] s1_q, s1_d, s2_q, s2_d, h1_q, h1_d, h2_q, h2_d;

    always_comb begin
        s1_d = fault;
        s2_d = s1_q;
        h1_d = s2_q;
        h2_d = h1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            h1_q <= '0;
            h2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            h1_q <= h1_d;
            h2_q <= h2_d;
        end
    end

    assign fault_f = s2_q & h1_q & h2_q;
`else
    assign fault_f = fault;
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam int LIM = SETTLE_BASE * (k + 1) - 1;

        state_e             state_q, state_d;
        logic [CNT_W-1:0]   cnt_q, cnt_d;
        logic [1:0]         cause_q, cause_d;
        logic               any_fault, up_ok, permit, drop, at_lim;

        if (k == 0) begin : g_head
            assign up_ok = 1'b1;
        end else begin : g_casc
            assign up_ok = ch_ok[k-1];
        end

        assign any_fault = |fault_f[k*NUM_FAULTS +: NUM_FAULTS];
        assign permit    = ~any_fault & ext_ready[k] & up_ok;
        assign drop      = ~ps_act[k] | ~ext_ready[k] | ~up_ok;
        assign at_lim    = (cnt_q == CNT_W'(LIM));

        // Priority: fault > undervoltage > supply/upstream drop > settle expiry.
        always_comb begin
            state_d = state_q;
            cnt_d   = '0;
            cause_d = cause_q;
            case (state_q)
                IDLE: begin
                    if (any_fault) begin
                        state_d = TRIP;
                        cause_d = 2'b01;
                    end else if (permit && ps_act[k]) begin
                        state_d = RAMP;
                    end
                end
                RAMP: begin
                    if (any_fault) begin
                        state_d = TRIP;
                        cause_d = 2'b01;
                    end else if (at_lim && u_low[k]) begin
                        state_d = TRIP;
                        cause_d = 2'b10;
                    end else if (drop) begin
                        state_d = IDLE;
                    end else if (at_lim) begin
                        state_d = OK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                OK: begin
                    if (any_fault) begin
                        state_d = TRIP;
                        cause_d = 2'b01;
                    end else if (u_low[k]) begin
                        state_d = TRIP;
                        cause_d = 2'b10;
                    end else if (drop) begin
                        state_d = IDLE;
                    end
                end
                TRIP: begin
                    // Trip is only released with the fault gone and the supply off.
                    if (clear && !any_fault && !ps_act[k]) begin
                        state_d = IDLE;
                        cause_d = 2'b00;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                cause_q <= 2'b00;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                cause_q <= cause_d;
            end
        end

        assign on_perm[k]          = permit & (state_q != TRIP);
        assign ch_ok[k]            = (state_q == OK);
        assign alarm[k]            = (state_q == TRIP);
        assign busy[k]             = (state_q == RAMP);
        assign trip_cause[2*k +: 2] = cause_q;
    end

endmodule

// File: tb/tb_rpsc_ps_interlock.sv
// Self-checking bench for rpsc_ps_interlock (NUM_CH=2, SETTLE_BASE=8).
// Directed sequencing / trip / clear / shutdown / reset scenarios followed by
// randomized stimulus, all checked every cycle against a behavioural model.
module tb_rpsc_ps_interlock;

    localparam int NCH = 2;
    localparam int NF  = 7;
    localparam int SB  = 8;

    localparam int M_IDLE = 0, M_RAMP = 1, M_OK = 2, M_TRIP = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH*NF-1:0] fault;
    logic [NCH-1:0]    ext_ready, ps_act, u_low;
    logic              clear;
    logic [NCH-1:0]    on_perm, ch_ok, alarm, busy;
    logic [2*NCH-1:0]  trip_cause;

    int n_chk  = 0;
    int n_pass = 0;

    // model: operating mode, cycles spent ramping, latched cause
    int m_mode  [NCH];
    int m_age   [NCH];
    int m_cause [NCH];

    rpsc_ps_interlock #(.NUM_CH(NCH), .NUM_FAULTS(NF), .SETTLE_BASE(SB)) dut (
        .clk(clk), .reset(reset), .fault(fault), .ext_ready(ext_ready),
        .ps_act(ps_act), .u_low(u_low), .clear(clear), .on_perm(on_perm),
        .ch_ok(ch_ok), .alarm(alarm), .trip_cause(trip_cause), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic bit ch_fault(int k);
        logic [NCH*NF-1:0] f;
        f = fault >> (k * NF);
        return |f[NF-1:0];
    endfunction

    function automatic bit upstream_ok(int k, const ref int modes[NCH]);
        return (k == 0) || (modes[k-1] == M_OK);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_mode[k] = M_IDLE; m_age[k] = 0; m_cause[k] = 0;
        end
    endtask

    // One clock edge of the interlock rules, evaluated on pre-edge modes.
    task automatic model_edge();
        int old[NCH];
        old = m_mode;
        for (int k = 0; k < NCH; k++) begin
            bit f, up, leave, done;
            int settle;
            f      = ch_fault(k);
            up     = upstream_ok(k, old);
            leave  = !ps_act[k] || !ext_ready[k] || !up;
            settle = SB * (k + 1);
            done   = (m_age[k] + 1 == settle);
            if (old[k] == M_IDLE) begin
                if (f) begin m_mode[k] = M_TRIP; m_cause[k] = 1; end
                else if (ext_ready[k] && up && ps_act[k]) begin m_mode[k] = M_RAMP; m_age[k] = 0; end
            end else if (old[k] == M_RAMP) begin
                if (f) begin m_mode[k] = M_TRIP; m_cause[k] = 1; end
                else if (done && u_low[k]) begin m_mode[k] = M_TRIP; m_cause[k] = 2; end
                else if (leave) m_mode[k] = M_IDLE;
                else if (done) m_mode[k] = M_OK;
                else m_age[k]++;
            end else if (old[k] == M_OK) begin
                if (f) begin m_mode[k] = M_TRIP; m_cause[k] = 1; end
                else if (u_low[k]) begin m_mode[k] = M_TRIP; m_cause[k] = 2; end
                else if (leave) m_mode[k] = M_IDLE;
            end else begin
                if (clear && !f && !ps_act[k]) begin m_mode[k] = M_IDLE; m_cause[k] = 0; end
            end
            if (m_mode[k] != M_RAMP) m_age[k] = 0;
        end
    endtask

    task automatic check_all();
        logic [NCH-1:0]   e_perm, e_ok, e_alm, e_busy;
        logic [2*NCH-1:0] e_cause;
        for (int k = 0; k < NCH; k++) begin
            e_perm[k] = !ch_fault(k) && ext_ready[k] && upstream_ok(k, m_mode) && (m_mode[k] != M_TRIP);
            e_ok[k]   = (m_mode[k] == M_OK);
            e_alm[k]  = (m_mode[k] == M_TRIP);
            e_busy[k] = (m_mode[k] == M_RAMP);
            e_cause[2*k +: 2] = 2'(m_cause[k]);
        end
        chk("on_perm", 32'(on_perm), 32'(e_perm));
        chk("ch_ok", 32'(ch_ok), 32'(e_ok));
        chk("alarm", 32'(alarm), 32'(e_alm));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("trip_cause", 32'(trip_cause), 32'(e_cause));
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; fault = '0; ext_ready = '0; ps_act = '0; u_low = '0; clear = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_outputs", 32'({ch_ok, alarm, busy, trip_cause}), 32'd0);
        reset = 1'b0;
        ext_ready = 2'b11;

        // sequencing: ch0 settles in 8 cycles, then ch1 in 16
        ps_act = 2'b01;
        step();
        chk("seq_busy0", 32'(busy[0]), 32'd1);
        chk("seq_perm1_blocked", 32'(on_perm[1]), 32'd0);
        repeat (7) step();
        chk("seq_ok0_early", 32'(ch_ok[0]), 32'd0);
        step();
        chk("seq_ok0", 32'(ch_ok[0]), 32'd1);
        ps_act = 2'b11;
        step();
        chk("seq_busy1", 32'(busy[1]), 32'd1);
        repeat (15) step();
        chk("seq_ok1_early", 32'(ch_ok[1]), 32'd0);
        step();
        chk("seq_ok1", 32'(ch_ok[1]), 32'd1);

        // one-cycle fault on bit 3 (ch0), cascade drop of ch1
        fault = 14'h0008;
        #1 chk("flt_perm0_comb", 32'(on_perm[0]), 32'd0);
        step();
        fault = '0;
        chk("flt_alarm0", 32'(alarm[0]), 32'd1);
        chk("flt_cause0", 32'(trip_cause[1:0]), 32'd1);
        chk("flt_ok1_still", 32'(ch_ok[1]), 32'd1);
        step();
        chk("flt_ok1_drop", 32'(ch_ok[1]), 32'd0);
        chk("flt_alarm1", 32'(alarm[1]), 32'd0);

        // clear ignored while supply still active
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_held", 32'(alarm[0]), 32'd1);
        ps_act = 2'b00; clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_alarm0", 32'(alarm[0]), 32'd0);
        chk("clr_cause0", 32'(trip_cause[1:0]), 32'd0);

        // undervoltage at end of settle
        ps_act = 2'b01; u_low = 2'b01;
        step();
        repeat (7) step();
        chk("uv_busy0", 32'(busy[0]), 32'd1);
        step();
        chk("uv_alarm0", 32'(alarm[0]), 32'd1);
        chk("uv_cause0", 32'(trip_cause[1:0]), 32'd2);
        chk("uv_ok0", 32'(ch_ok[0]), 32'd0);
        u_low = '0; ps_act = '0; clear = 1'b1;
        step();
        clear = 1'b0;

        // normal shutdown, no latch
        ps_act = 2'b01;
        repeat (9) step();
        chk("sd_ok0", 32'(ch_ok[0]), 32'd1);
        ps_act = 2'b00;
        step();
        chk("sd_ok0_off", 32'(ch_ok[0]), 32'd0);
        chk("sd_alarm0", 32'(alarm[0]), 32'd0);

        // reset mid-RAMP at counter 5, then a full ramp afterwards
        ps_act = 2'b01;
        repeat (6) step();
        #2 reset = 1'b1;
        #1 chk("rst_mid_ramp", 32'({ch_ok, alarm, busy, trip_cause}), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step();
        repeat (7) step();
        chk("rst_ramp_full", 32'(ch_ok[0]), 32'd0);
        step();
        chk("rst_ramp_ok", 32'(ch_ok[0]), 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int b;
            fault = ($urandom_range(0, 39) == 0) ? (14'(1) << $urandom_range(0, 13)) : '0;
            ext_ready = ($urandom_range(0, 29) == 0) ? 2'($urandom) : 2'b11;
            for (int k = 0; k < NCH; k++)
                if ($urandom_range(0, 24) == 0) ps_act[k] = ~ps_act[k];
            b = $urandom_range(0, 59);
            u_low = (b == 0) ? 2'($urandom) : 2'b00;
            clear = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rpsc_ps_interlock.md
Name: rpsc_ps_interlock

Overview:
- Parametrised multi-channel power-supply interlock and sequencer for RPSC cards; generalises the per-card grid/anode permit and settle-check logic to NUM_CH cascaded supply channels.
- Each channel has its own fault group and a per-channel settle timer.
- Each channel has a state machine that latches trips.
- Channel k is permitted only when channel k-1 is OK, giving an enforced power-up order (e.g. G1 before anode).

Parameters:
- NUM_CH, 2, number of cascaded supply channels (≥1).
- NUM_FAULTS, 7, fault inputs per channel.
- SETTLE_BASE, 128, settle unit in clk cycles; channel k settles for SETTLE_BASE*(k+1) cycles (ch0=128, ch1=256).
- CNT_W, $clog2(SETTLE_BASE*NUM_CH+1), settle counter width (derived; do not override).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- fault  in  NUM_CH*NUM_FAULTS  active-high faults; bits [k*NUM_FAULTS +: NUM_FAULTS] belong to channel k.
- ext_ready  in  NUM_CH  external readiness per channel (thermal, upstream card OK).
- ps_act  in  NUM_CH  supply-active feedback per channel.
- u_low  in  NUM_CH  output-voltage-low flag per channel.
- clear  in  1  single-cycle trip acknowledge, applies to all channels.
- on_perm  out  NUM_CH  switch-on permission per channel (combinational).
- ch_ok  out  NUM_CH  channel settled and healthy (registered).
- alarm  out  NUM_CH  latched trip indication (registered).
- trip_cause  out  2*NUM_CH  per channel: 00 none, 01 fault, 10 undervoltage.
- busy  out  NUM_CH  channel in RAMP (registered).

Behaviour:
- Reset values: all channels in IDLE; counters 0; ch_ok=0, alarm=0, trip_cause=0, busy=0.
- Channel k signals:
  - any_fault_k = OR of channel k's fault bits.
  - up_ok_k = 1 for k=0, otherwise ch_ok[k-1].
  - permit_k = ~any_fault_k & ext_ready[k] & up_ok_k.
  - on_perm[k] = permit_k & (state≠TRIP), combinational.
- Per-channel FSM, states IDLE, RAMP, OK, TRIP. Evaluation priority each edge: any_fault > u_low check > ps_act drop / upstream loss > counter expiry.
- IDLE:
  - any_fault → TRIP, cause 01.
  - permit_k & ps_act[k] → RAMP, counter←0.
  - Otherwise stay.
- RAMP (busy=1):
  - any_fault → TRIP, cause 01.
  - ~ps_act[k], ~ext_ready[k] or ~up_ok_k → IDLE (no latch).
  - Otherwise counter increments.
  - At counter = SETTLE_BASE*(k+1)-1: u_low[k] → TRIP, cause 10; else → OK.
- OK (ch_ok=1):
  - any_fault → TRIP, cause 01.
  - u_low[k] → TRIP, cause 10.
  - ~ps_act[k], ~ext_ready[k] or ~up_ok_k → IDLE (normal shutdown / cascade drop, not latched).
- TRIP (alarm=1, on_perm=0):
  - Leaves to IDLE only on the edge where clear=1, any_fault_k=0 and ps_act[k]=0. On that transition trip_cause←00.
  - clear is ignored otherwise, and in all other states.
- Outputs are decoded from registered state, so a fault asserted before edge N gives alarm=1 and ch_ok=0 after edge N. on_perm drops in the same cycle as the fault (combinational).
- Cascade: downstream channel drop following an upstream drop takes one extra cycle per channel stage (ch_ok is registered).
- Counter does not wrap; it is held at 0 outside RAMP.
- Reset asserted mid-RAMP or in TRIP: immediate return to reset values; trips do not survive reset.

Optional Feature:
- Macro: RPSC_FAULT_FILTER_EN.
- Defined: each fault bit passes through a 2-flop synchronizer, then a 3-cycle debounce. The bit counts as asserted only after 3 consecutive high synchronized samples, and deasserts immediately when a synchronized sample is low.
  - Fault-to-TRIP latency becomes 5 edges.
  - Glitches shorter than 3 cycles are ignored.
  - Filter flops reset to 0.
- Undefined: raw fault used directly; fault-to-TRIP latency 1 edge.

Test Plan:
- Sequencing, NUM_CH=2, SETTLE_BASE=8, no faults, ext_ready=11:
  - Set ps_act[0]=1 → busy[0]=1; ch_ok[0]=1 after 8 cycles.
  - Then set ps_act[1]=1 → ch_ok[1]=1 after 16 more cycles.
  - on_perm[1] stays 0 until ch_ok[0]=1.
- Fault trip: both channels OK; pulse fault bit 3 (ch0) for 1 cycle.
  - on_perm[0]=0 immediately; alarm[0]=1, trip_cause[1:0]=01 after 1 edge.
  - ch1 returns to IDLE with ch_ok[1]=0 one edge later; alarm[1]=0.
- Undervoltage at settle end: ch0 RAMP with u_low[0]=1 held.
  - At cycle 8 → TRIP, trip_cause=10, ch_ok[0] never rises.
- Clear rules: ch0 in TRIP.
  - clear=1 with ps_act[0]=1 → stays TRIP.
  - ps_act[0]=0 with clear=1 → IDLE, alarm=0, cause=00.
- Normal shutdown: ch0 OK; drop ps_act[0] → IDLE, alarm[0]=0, ch_ok[0]=0; no latch.
- Reset mid-RAMP: assert reset at counter=5 → all outputs 0 asynchronously. After release, a new RAMP takes the full 8 cycles.
